// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the MDR/MAR memory responder.
package minisrc_mem_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned DEPTH_DEF  = 512;
   localparam int unsigned MEM_ADDR_W = $clog2(DEPTH_DEF);
   localparam int unsigned CNT_W      = 4;
   localparam int unsigned BUS_ADDR_W = 32;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   typedef enum logic [1:0] {
      OP_RD  = 2'd0,
      OP_WR  = 2'd1,
      OP_BAD = 2'd2
   } op_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the datapath (master) and the memory responder (slave).
interface mem_responder_if #(parameter int unsigned DATA_W = 32);

   logic [31:0]       mar_addr;
   logic [DATA_W-1:0] mdr_wdata;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] mdatain;
   logic              mem_done;
   logic              mem_err;
   logic              busy;

   modport master (
      output mar_addr, mdr_wdata, read, write,
      input  mdatain, mem_done, mem_err, busy
   );

   modport slave (
      input  mar_addr, mdr_wdata, read, write,
      output mdatain, mem_done, mem_err, busy
   );

endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous RAM with registered read data; storage is never reset.
module mem_array #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 512
) (
   input  logic                     clock,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: latches a MAR/MDR request, waits WAIT_STATES cycles, commits, pulses mem_done.
// Optional MEM_ADDR_CHECK_EN rejects addresses >= DEPTH instead of wrapping them.
module mem_responder
   import minisrc_mem_pkg::*;
#(
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned DEPTH       = DEPTH_DEF,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic            clock,
   input  logic            clear,
   mem_responder_if.slave  bus
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [1:0]        state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   op_t               op_q, op_d;
   logic [DATA_W-1:0] mdatain_q, mdatain_d;
   logic              done_q, done_d, err_q, err_d, busy_q, busy_d;
   logic              ram_we_c, range_bad_c;
   logic [AW-1:0]     ram_addr_c;
   logic [DATA_W-1:0] ram_rdata;

`ifdef MEM_ADDR_CHECK_EN
   assign range_bad_c = (bus.mar_addr >= BUS_ADDR_W'(DEPTH));
`else
   logic unused_addr_hi;
   assign unused_addr_hi = ^bus.mar_addr[BUS_ADDR_W-1:AW];
   assign range_bad_c    = 1'b0;
`endif

   // Read the incoming address while idle so the data is ready even with zero wait states.
   assign ram_addr_c = (state == S_IDLE) ? bus.mar_addr[AW-1:0] : addr_q;

   mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
      .clock (clock),
      .we    (ram_we_c & clear),
      .addr  (ram_addr_c),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clock) begin
      if (!clear) begin
         state     <= S_IDLE;
         cnt       <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         op_q      <= OP_RD;
         mdatain_q <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         op_q      <= op_d;
         mdatain_q <= mdatain_d;
         done_q    <= done_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      op_d      = op_q;
      mdatain_d = mdatain_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      ram_we_c  = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.read || bus.write) begin
               addr_d  = bus.mar_addr[AW-1:0];
               wdata_d = bus.mdr_wdata;
               if ((bus.read && bus.write) || range_bad_c) op_d = OP_BAD;
               else if (bus.write)                         op_d = OP_WR;
               else                                        op_d = OP_RD;
               cnt_d   = CNT_W'(WAIT_STATES);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt != '0) begin
               cnt_d = cnt - CNT_W'(1);
            end else begin
               // Commit edge: the only place the array or mdatain changes.
               ram_we_c = (op_q == OP_WR);
               if (op_q == OP_RD) mdatain_d = ram_rdata;
               done_d  = 1'b1;
               err_d   = (op_q == OP_BAD);
               state_d = S_DONE;
            end
         end
         S_DONE: state_d = S_HOLD;
         S_HOLD: if (!bus.read && !bus.write) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   assign bus.mdatain  = mdatain_q;
   assign bus.mem_done = done_q;
   assign bus.mem_err  = err_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed, table-driven bench for mem_responder (WAIT_STATES=2 and WAIT_STATES=0 instances).
module tb_mem_responder;

   logic clk = 1'b0;
   logic clear = 1'b0;
   always #5 clk = ~clk;

   mem_responder_if #(.DATA_W(32)) bus  ();
   mem_responder_if #(.DATA_W(32)) bus0 ();

   mem_responder #(.DATA_W(32), .DEPTH(512), .WAIT_STATES(2)) dut (
      .clock (clk), .clear (clear), .bus (bus)
   );
   mem_responder #(.DATA_W(32), .DEPTH(512), .WAIT_STATES(0)) dut0 (
      .clock (clk), .clear (clear), .bus (bus0)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        err;
      logic [31:0] data;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input int w, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd);
      if (w == 0) begin
         bus.read = rd; bus.write = wr; bus.mar_addr = addr; bus.mdr_wdata = wd;
      end else begin
         bus0.read = rd; bus0.write = wr; bus0.mar_addr = addr; bus0.mdr_wdata = wd;
      end
   endtask

   function automatic logic done_of(input int w);
      return (w == 0) ? bus.mem_done : bus0.mem_done;
   endfunction
   function automatic logic err_of(input int w);
      return (w == 0) ? bus.mem_err : bus0.mem_err;
   endfunction
   function automatic logic busy_of(input int w);
      return (w == 0) ? bus.busy : bus0.busy;
   endfunction
   function automatic logic [31:0] dat_of(input int w);
      return (w == 0) ? bus.mdatain : bus0.mdatain;
   endfunction

   // lat = sampling edge (1 = capture edge) at which mem_done is first seen high.
   task automatic run_op(input int w, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd, input int hold,
                         output int lat, output int ndone, output logic err,
                         output logic [31:0] data, output int busy_bad, output logic busy_after);
      lat = -1; ndone = 0; err = 1'b0; data = '0; busy_bad = 0; busy_after = 1'b1;
      @(negedge clk);
      drive(w, rd, wr, addr, wd);
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done_of(w)) begin
            ndone++;
            if (lat < 0) begin
               lat = k; err = err_of(w); data = dat_of(w);
            end
         end else if (lat < 0 && !busy_of(w)) begin
            busy_bad++;
         end
         if (lat >= 0 && k >= lat + hold) break;
      end
      @(negedge clk);
      drive(w, 1'b0, 1'b0, addr, wd);
      @(posedge clk); #1;
      if (done_of(w)) ndone++;
      busy_after = busy_of(w);
      @(posedge clk); #1;
      if (done_of(w)) ndone++;
   endtask

   function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wd, input logic err, input logic [31:0] data);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.err = err; v.data = data;
      return v;
   endfunction

   initial begin
      int          lat, nd, bb;
      logic        err, ba;
      logic [31:0] data;

      vecs[0]  = mk(1'b0, 1'b1, 32'h010, 32'hBEEF_BEEF, 1'b0, 32'h0000_0000);
      vecs[1]  = mk(1'b1, 1'b0, 32'h010, 32'h0,         1'b0, 32'hBEEF_BEEF);
      vecs[2]  = mk(1'b1, 1'b1, 32'h010, 32'h1111_1111, 1'b1, 32'hBEEF_BEEF);
      vecs[3]  = mk(1'b1, 1'b0, 32'h010, 32'h0,         1'b0, 32'hBEEF_BEEF);
      vecs[4]  = mk(1'b0, 1'b1, 32'h020, 32'h1234_5678, 1'b0, 32'hBEEF_BEEF);
      vecs[5]  = mk(1'b0, 1'b1, 32'h000, 32'h0BAD_F00D, 1'b0, 32'hBEEF_BEEF);
`ifdef MEM_ADDR_CHECK_EN
      vecs[6]  = mk(1'b0, 1'b1, 32'h200, 32'hA5A5_A5A5, 1'b1, 32'hBEEF_BEEF);
      vecs[7]  = mk(1'b1, 1'b0, 32'h000, 32'h0,         1'b0, 32'h0BAD_F00D);
`else
      vecs[6]  = mk(1'b0, 1'b1, 32'h200, 32'hA5A5_A5A5, 1'b0, 32'hBEEF_BEEF);
      vecs[7]  = mk(1'b1, 1'b0, 32'h000, 32'h0,         1'b0, 32'hA5A5_A5A5);
`endif
      vecs[8]  = mk(1'b0, 1'b1, 32'h1FF, 32'hCAFE_F00D, 1'b0, vecs[7].data);
      vecs[9]  = mk(1'b1, 1'b0, 32'h1FF, 32'h0,         1'b0, 32'hCAFE_F00D);
      vecs[10] = mk(1'b0, 1'b1, 32'h010, 32'h2222_2222, 1'b0, 32'hCAFE_F00D);

      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      clear = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mdatain", bus.mdatain, 32'h0);
      chk("rst_done", 32'(bus.mem_done), 32'h0);
      chk("rst_err", 32'(bus.mem_err), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      @(negedge clk);
      clear = 1'b1;

      foreach (vecs[i]) begin
         run_op(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, 0,
                lat, nd, err, data, bb, ba);
         chk($sformatf("v%0d_lat", i), 32'(lat), 32'd4);
         chk($sformatf("v%0d_ndone", i), 32'(nd), 32'd1);
         chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
         chk($sformatf("v%0d_data", i), data, vecs[i].data);
         chk($sformatf("v%0d_busy", i), 32'(bb), 32'd0);
      end

      // Abort an in-flight write with clear during WAIT.
      @(negedge clk);
      drive(0, 1'b0, 1'b1, 32'h020, 32'hFEED_FEED);
      @(posedge clk); #1;
      chk("abort_busy_wait", 32'(bus.busy), 32'h1);
      @(negedge clk);
      clear = 1'b0;
      @(posedge clk); #1;
      chk("abort_busy", 32'(bus.busy), 32'h0);
      chk("abort_mdatain", bus.mdatain, 32'h0);
      chk("abort_done", 32'(bus.mem_done), 32'h0);
      @(negedge clk);
      clear = 1'b1;
      drive(0, 1'b0, 1'b0, 32'h020, 32'h0);
      run_op(0, 1'b1, 1'b0, 32'h020, 32'h0, 0, lat, nd, err, data, bb, ba);
      chk("abort_read", data, 32'h1234_5678);
      chk("abort_read_lat", 32'(lat), 32'd4);

      // Request held long after completion is serviced once; release returns to idle next edge.
      run_op(0, 1'b1, 1'b0, 32'h010, 32'h0, 10, lat, nd, err, data, bb, ba);
      chk("hold_ndone", 32'(nd), 32'd1);
      chk("hold_data", data, 32'h2222_2222);
      chk("hold_idle", 32'(ba), 32'h0);

      // Zero wait states.
      run_op(1, 1'b0, 1'b1, 32'h010, 32'h5A5A_0001, 0, lat, nd, err, data, bb, ba);
      chk("ws0_wr_lat", 32'(lat), 32'd2);
      chk("ws0_wr_data", data, 32'h0);
      run_op(1, 1'b1, 1'b0, 32'h010, 32'h0, 0, lat, nd, err, data, bb, ba);
      chk("ws0_rd_lat", 32'(lat), 32'd2);
      chk("ws0_rd_data", data, 32'h5A5A_0001);
      chk("ws0_rd_err", 32'(err), 32'h0);
      run_op(1, 1'b1, 1'b1, 32'h010, 32'h0, 0, lat, nd, err, data, bb, ba);
      chk("ws0_bad_err", 32'(err), 32'h1);
      chk("ws0_bad_data", data, 32'h5A5A_0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
